// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter: requester count, index width,
// FSM state encodings and the 3-to-8 grant decoder.
package bus_arbiter_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

  // 3-to-8 select decoder feeding the bus mux enables.
  function automatic logic [N_REQ-1:0] dec3to8(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] onehot;
    onehot      = '0;
    onehot[idx] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Rotating priority encoder: returns the first set request found when
// scanning from i_ptr upward, modulo N_REQ. Purely combinational so it can
// be shared with other round-robin clients.
module rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_any,
  output logic [IDX_W-1:0] o_idx
);

  // Scan from farthest to nearest so the nearest set bit from i_ptr wins.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_any = 1'b0;
    o_idx = i_ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (i_req[i_ptr + IDX_W'(i)]) begin
        o_any = 1'b1;
        o_idx = i_ptr + IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared internal data bus (8 requesters).
// All outputs are registered; one turnaround GAP cycle follows every grant.
// Optional feature: define ARB_TIMEOUT_EN to force release of an owner after
// MAX_HOLD grant cycles and pulse o_timeout in the following GAP cycle.
module bus_arbiter
  import bus_arbiter_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
  parameter int MAX_HOLD = 16
)
`endif
(
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_release,
  output logic             o_grant_valid,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic [N_REQ-1:0] o_grant_onehot,
  output logic             o_busy,
  output logic             o_timeout
);

  arb_state_e       r_state;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_grant_idx;
  logic             r_grant_valid;
  logic [N_REQ-1:0] r_grant_onehot;
  logic             r_busy;

  logic             w_any;
  logic [IDX_W-1:0] w_winner;
  logic             w_exit;
  logic             w_forced;

  rr_pick u_rr_pick (
    .i_req (i_req),
    .i_ptr (r_rr_ptr),
    .o_any (w_any),
    .o_idx (w_winner)
  );

  // Owner is done when it pulses release or drops its request.
  assign w_exit = i_release | ~i_req[r_grant_idx];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_hold_cnt;
  logic       r_timeout;

  assign w_forced  = (r_hold_cnt == 8'(MAX_HOLD - 1)) && !i_release;
  assign o_timeout = r_timeout;

  // Hold counter: cleared on grant, counts each cycle the grant is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= (r_state == ST_GRANT) && w_forced;
      if (r_state != ST_GRANT) r_hold_cnt <= '0;
      else if (!w_exit)        r_hold_cnt <= r_hold_cnt + 8'd1;
    end
  end
`else
  assign w_forced  = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // Arbitration FSM; winners are picked in IDLE and at the end of GAP.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge here, so it sits inside the clocked branch.
    if (reset) begin
      r_state        <= ST_IDLE;
      r_rr_ptr       <= '0;
      r_grant_idx    <= '0;
      r_grant_valid  <= 1'b0;
      r_grant_onehot <= '0;
      r_busy         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      unique case (r_state)
        ST_IDLE, ST_GAP: begin
          if (w_any) begin
            r_state        <= ST_GRANT;
            r_grant_idx    <= w_winner;
            r_grant_valid  <= 1'b1;
            r_grant_onehot <= dec3to8(w_winner);
            r_busy         <= 1'b1;
            r_rr_ptr       <= w_winner + IDX_W'(1);
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (w_exit || w_forced) begin
            r_state        <= ST_GAP;
            r_grant_valid  <= 1'b0;
            r_grant_onehot <= '0;
          end
        end
        default: begin
          r_state        <= ST_IDLE;
          r_grant_valid  <= 1'b0;
          r_grant_onehot <= '0;
          r_busy         <= 1'b0;
        end
      endcase
    end
  end

  assign o_grant_valid  = r_grant_valid;
  assign o_grant_idx    = r_grant_idx;
  assign o_grant_onehot = r_grant_onehot;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: a per-cycle vector table followed by
// hand-written sequences for round-robin wrap and long-hold behaviour.
module tb_bus_arbiter;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic       rel;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic [7:0] grant_onehot;
  logic       busy;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ARB_TIMEOUT_EN
  bus_arbiter #(.MAX_HOLD(4)) dut (
`else
  bus_arbiter dut (
`endif
    .clk            (clk),
    .reset          (reset),
    .i_req          (req),
    .i_release      (rel),
    .o_grant_valid  (grant_valid),
    .o_grant_idx    (grant_idx),
    .o_grant_onehot (grant_onehot),
    .o_busy         (busy),
    .o_timeout      (timeout)
  );

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       rel;
    logic       ev;
    logic [2:0] eidx;
    logic [7:0] eoh;
    logic       eb;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs mid-cycle, then sample outputs shortly after the rising edge.
  task automatic step(input logic r, input logic [7:0] rq, input logic rl);
    @(negedge clk);
    reset = r;
    req   = rq;
    rel   = rl;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [2:0] eidx,
                            input logic [7:0] eoh, input logic eb, input logic eto);
    check({tag, " valid"}, 32'(grant_valid), 32'(ev));
    if (ev) check({tag, " idx"}, 32'(grant_idx), 32'(eidx));
    check({tag, " onehot"}, 32'(grant_onehot), 32'(eoh));
    check({tag, " busy"}, 32'(busy), 32'(eb));
    check({tag, " timeout"}, 32'(timeout), 32'(eto));
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    rel   = 1'b0;

    //          rst   req    rel   ev    idx   onehot busy
    vecs[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0}; // reset state
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0}; // release in IDLE ignored
    vecs[2]  = '{1'b0, 8'h04, 1'b0, 1'b1, 3'd2, 8'h04, 1'b1}; // grant 2, ptr->3
    vecs[3]  = '{1'b0, 8'h04, 1'b0, 1'b1, 3'd2, 8'h04, 1'b1}; // held
    vecs[4]  = '{1'b0, 8'h04, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1}; // release -> GAP
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0}; // no req -> IDLE
    vecs[6]  = '{1'b0, 8'h21, 1'b0, 1'b1, 3'd5, 8'h20, 1'b1}; // from ptr 3 -> 5, ptr->6
    vecs[7]  = '{1'b0, 8'h01, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1}; // release + drop: one GAP
    vecs[8]  = '{1'b0, 8'h01, 1'b0, 1'b1, 3'd0, 8'h01, 1'b1}; // wrap 6,7,0 -> 0, ptr->1
    vecs[9]  = '{1'b0, 8'h08, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1}; // owner dropped -> GAP
    vecs[10] = '{1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 8'h08, 1'b1}; // grant 3, ptr->4
    vecs[11] = '{1'b1, 8'h08, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0}; // reset mid-GRANT
    vecs[12] = '{1'b0, 8'h18, 1'b0, 1'b1, 3'd3, 8'h08, 1'b1}; // ptr back at 0 -> 3, not 4
    vecs[13] = '{1'b0, 8'h18, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1}; // release -> GAP
    vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0}; // IDLE
    vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0}; // release in IDLE ignored

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].rel);
      check_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eidx, vecs[i].eoh, vecs[i].eb, 1'b0);
    end

    // All requesting, release every grant: 0..7 then wrap to 0, one GAP between.
    step(1'b1, 8'h00, 1'b0);
    step(1'b0, 8'hFF, 1'b0);
    check_outs("rr grant0", 1'b1, 3'd0, 8'h01, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 8'hFF, 1'b1);
      check_outs($sformatf("rr gap%0d", k), 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'hFF, 1'b0);
      check_outs($sformatf("rr grant%0d", k), 1'b1, 3'(k % 8), 8'h01 << (k % 8), 1'b1, 1'b0);
    end

    // Long hold with two requesters and no release.
    step(1'b1, 8'h00, 1'b0);
    step(1'b0, 8'h03, 1'b0);
    check_outs("hold grant", 1'b1, 3'd0, 8'h01, 1'b1, 1'b0);
`ifdef ARB_TIMEOUT_EN
    for (int c = 1; c < 4; c++) begin
      step(1'b0, 8'h03, 1'b0);
      check_outs($sformatf("to hold%0d", c), 1'b1, 3'd0, 8'h01, 1'b1, 1'b0);
    end
    step(1'b0, 8'h03, 1'b0);
    check_outs("to gap", 1'b0, 3'd0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h03, 1'b0);
    check_outs("to next", 1'b1, 3'd1, 8'h02, 1'b1, 1'b0);
`else
    for (int c = 1; c < 24; c++) begin
      step(1'b0, 8'h03, 1'b0);
      check_outs($sformatf("hold%0d", c), 1'b1, 3'd0, 8'h01, 1'b1, 1'b0);
    end
    step(1'b0, 8'h03, 1'b1);
    check_outs("hold gap", 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h03, 1'b0);
    check_outs("hold next", 1'b1, 3'd1, 8'h02, 1'b1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
